// File: rtl/tholin_mac_pkg.sv
// Shared widths, op encodings and readout FSM states for the tholin MAC accumulator.
package tholin_mac_pkg;
  localparam int ACC_W = 16;
  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] OP_ACC  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND_HI = 2'b01,
    ST_SEND_LO = 2'b10,
    ST_SEND_ST = 2'b11
  } state_e;
endpackage

// File: rtl/tholin_mac_alu.sv
// Combinational next-state math for the accumulator: add/sub/load/clear plus saturating count.
module tholin_mac_alu
  import tholin_mac_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [7:0]       prod,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] cnt,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             carry,
  output logic [CNT_W-1:0] cnt_nxt
);
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    prod_ext = {{(ACC_W + 1 - 8){1'b0}}, prod};
    sum      = {1'b0, acc} + prod_ext;
    // Bit ACC_W of the widened difference is the borrow out of the 16-bit subtract.
    diff     = {1'b0, acc} - prod_ext;
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    acc_nxt = acc;
    carry   = 1'b0;
    cnt_nxt = cnt;
    case (op)
      OP_ACC: begin
        acc_nxt = sum[ACC_W-1:0];
        carry   = sum[ACC_W];
        cnt_nxt = cnt_inc;
      end
      OP_SUB: begin
        acc_nxt = diff[ACC_W-1:0];
        carry   = diff[ACC_W];
        cnt_nxt = cnt_inc;
      end
      OP_LOAD: begin
        acc_nxt = prod_ext[ACC_W-1:0];
        cnt_nxt = CNT_W'(1);
      end
      default: begin
        acc_nxt = '0;
        cnt_nxt = '0;
      end
    endcase
  end
endmodule

// File: rtl/tholin_mac_accum.sv
// MAC back end: accumulates 8-bit products and streams a 3-byte snapshot (acc hi, acc lo, status).
module tholin_mac_accum
  import tholin_mac_pkg::*;
#(
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_prod,
  input  logic [1:0] in_op,
  input  logic       rd_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       busy
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [23:0]      snap_q, snap_d;

  logic [ACC_W-1:0] alu_acc;
  logic [CNT_W-1:0] alu_cnt;
  logic             alu_carry;
  logic             xfer;
  logic             rd_acc;

  tholin_mac_alu u_alu (
    .acc     (acc_q),
    .prod    (in_prod),
    .op      (in_op),
    .cnt     (cnt_q),
    .acc_nxt (alu_acc),
    .carry   (alu_carry),
    .cnt_nxt (alu_cnt)
  );

  // A snapshot request wins over a product offered in the same cycle.
  assign in_ready  = !rst && (state_q == ST_IDLE) && !rd_req;
  assign xfer      = in_valid && in_ready;
  assign rd_acc    = (state_q == ST_IDLE) && rd_req;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = busy;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    snap_d  = snap_q;

    if (rd_acc) begin
      snap_d  = {acc_q, ovf_q, cnt_q};
      state_d = ST_SEND_HI;
      if (CLR_ON_READ) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (xfer) begin
      acc_d = alu_acc;
      cnt_d = alu_cnt;
      ovf_d = ((in_op == OP_ACC) || (in_op == OP_SUB)) ? (ovf_q | alu_carry) : 1'b0;
    end

    if (out_ready) begin
      case (state_q)
        ST_SEND_HI: state_d = ST_SEND_LO;
        ST_SEND_LO: state_d = ST_SEND_ST;
        ST_SEND_ST: state_d = ST_IDLE;
        default:    ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_SEND_HI: out_byte = snap_q[23:16];
      ST_SEND_LO: out_byte = snap_q[15:8];
      ST_SEND_ST: out_byte = snap_q[7:0];
      default:    out_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      snap_q  <= snap_d;
    end
  end
endmodule
